// File: rtl/key_event_decoder_pkg.sv
// Shared definitions for the key event decoder: FSM state encodings, counter
// width and the default timing constants (50 MHz clock), together with the
// debounce mask time used by the upstream debouncer and the player control.
package key_event_decoder_pkg;

    // Width of the shared gesture counter; holds the largest default count.
    localparam int unsigned CNT_W = 26;

    // Default timing constants in clk cycles at 50 MHz.
    localparam int unsigned DEF_LONG_TIME = 32'd50_000_000; // 1 s hold
    localparam int unsigned DEF_DBL_TIME  = 32'd15_000_000; // 300 ms window
    localparam int unsigned DEF_RPT_TIME  = 32'd10_000_000; // 200 ms repeat
    localparam int unsigned MASK_TIME     = 32'd1_000_000;  // 20 ms debounce

    // Gesture FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HOLD   = 3'd4
    } kd_state_e;

    // Terminal count value for a period of t cycles (counter runs 0..t-1).
    function automatic logic [CNT_W-1:0] term_count(input int unsigned t);
        int unsigned tm1;
        tm1 = t - 32'd1;
        return tm1[CNT_W-1:0];
    endfunction

endpackage : key_event_decoder_pkg

// File: rtl/key_event_decoder_if.sv
// Key/gesture bundle: one debounced active-low key level in, four one-cycle
// gesture pulses out. The decoder takes the slave side.
interface key_event_decoder_if;
    logic click_n;   // debounced key level, active-low
    logic short_p;   // single short click
    logic double_p;  // double click
    logic long_p;    // hold reached the long-press time
    logic repeat_p;  // auto-repeat tick while held

    modport master (
        output click_n,
        input  short_p,
        input  double_p,
        input  long_p,
        input  repeat_p
    );

    modport slave (
        input  click_n,
        output short_p,
        output double_p,
        output long_p,
        output repeat_p
    );
endinterface : key_event_decoder_if

// File: rtl/key_event_decoder.sv
// Key event decoder: turns one debounced key level into short-click,
// double-click, long-press and auto-repeat pulses. One instance per key; the
// key is consumed directly with no extra synchronizer. A single 26-bit
// counter is shared by all timed states and restarts on every state change.
// The key level always wins over a terminal count reached in the same cycle.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_TIME = DEF_LONG_TIME,
    parameter int unsigned DBL_TIME  = DEF_DBL_TIME,
    parameter int unsigned RPT_TIME  = DEF_RPT_TIME
) (
    input  logic                clk,
    input  logic                rst_n,
    key_event_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LONG_TC = term_count(LONG_TIME);
    localparam logic [CNT_W-1:0] DBL_TC  = term_count(DBL_TIME);
    localparam logic [CNT_W-1:0] RPT_TC  = term_count(RPT_TIME);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    kd_state_e        r_state;
    kd_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_short;
    logic             r_double;
    logic             r_long;
    logic             r_repeat;
    logic             w_short_nxt;
    logic             w_double_nxt;
    logic             w_long_nxt;
    logic             w_repeat_nxt;
    logic             w_key_up;

    // Released key reads high; naming the level keeps the decode readable.
    assign w_key_up = bus.click_n;

    // Next-state, next-count and next-pulse decode for the gesture FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_ONE;
        w_short_nxt  = 1'b0;
        w_double_nxt = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = {CNT_W{1'b0}};
                if (!w_key_up) begin
                    w_state_nxt = ST_PRESS1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_PRESS1: begin
                if (w_key_up) begin
                    w_state_nxt = ST_WAIT2;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == LONG_TC) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_long_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end

            ST_WAIT2: begin
                if (!w_key_up) begin
                    w_state_nxt = ST_PRESS2;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else if (r_cnt == DBL_TC) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_short_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end

            ST_PRESS2: begin
                // No long detection here; the count only saturates so an
                // arbitrarily long second press can never wrap it.
                if (w_key_up) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    w_double_nxt = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt    = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_nxt    = r_cnt;
                end
            end

            ST_HOLD: begin
                if (w_key_up) begin
                    w_state_nxt  = ST_IDLE;
                    w_cnt_nxt    = {CNT_W{1'b0}};
                end else if (r_cnt == RPT_TC) begin
                    w_cnt_nxt    = {CNT_W{1'b0}};
                    w_repeat_nxt = 1'b1;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, shared counter and registered gesture pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CNT_W{1'b0}};
            r_short  <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short_nxt;
            r_double <= w_double_nxt;
            r_long   <= w_long_nxt;
            r_repeat <= w_repeat_nxt;
        end
    end

    assign bus.short_p  = r_short;
    assign bus.double_p = r_double;
    assign bus.long_p   = r_long;
    assign bus.repeat_p = r_repeat;

endmodule : key_event_decoder

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder with short sim timings. A timestamp-based
// gesture model predicts the pulse vector every cycle; directed scenarios
// also check absolute pulse latencies, then random press/gap sequences with
// occasional resets exercise the threshold boundaries.
module tb_key_event_decoder;

    localparam int LT = 100;
    localparam int DT = 30;
    localparam int RT = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    key_event_decoder_if kif ();

    key_event_decoder #(
        .LONG_TIME (LT),
        .DBL_TIME  (DT),
        .RPT_TIME  (RT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Gesture model: phase of the gesture and the sample index of the event
    // that started that phase. 0 none, 1 first press, 2 released awaiting a
    // second press, 3 second press, 4 held past the long-press time.
    int g_phase = 0;
    int g_since = 0;

    // Observation log.
    int t_short, t_double, t_long;
    int n_short, n_double, n_long, n_rpt;
    int rpt_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected pulses {short,double,long,repeat} after sample s of key level k.
    task automatic ref_step(input bit k, input int s, output logic [3:0] e);
        e = 4'b0000;
        case (g_phase)
            0: if (!k) begin g_phase = 1; g_since = s; end
            1: begin
                if (k) begin
                    g_phase = 2; g_since = s;
                end else if (s - g_since == LT) begin
                    g_phase = 4; g_since = s; e = 4'b0010;
                end
            end
            2: begin
                if (!k) begin
                    g_phase = 3;
                end else if (s - g_since == DT) begin
                    g_phase = 0; e = 4'b1000;
                end
            end
            3: if (k) begin g_phase = 0; e = 4'b0100; end
            4: begin
                if (k) g_phase = 0;
                else if ((s - g_since) % RT == 0) e = 4'b0001;
            end
            default: g_phase = 0;
        endcase
    endtask

    task automatic clear_log();
        t_short = -1000; t_double = -1000; t_long = -1000;
        n_short = 0; n_double = 0; n_long = 0; n_rpt = 0;
        rpt_q.delete();
    endtask

    // One clock with key level k; outputs checked 1 time unit after the edge.
    task automatic step(input bit k);
        logic [3:0] e;
        logic [3:0] got;
        kif.click_n = k;
        @(posedge clk);
        cyc++;
        ref_step(k, cyc, e);
        #1;
        got = {kif.short_p, kif.double_p, kif.long_p, kif.repeat_p};
        chk("pulses", 32'(got), 32'(e));
        if (got[3]) begin t_short  = cyc; n_short++;  end
        if (got[2]) begin t_double = cyc; n_double++; end
        if (got[1]) begin t_long   = cyc; n_long++;   end
        if (got[0]) begin rpt_q.push_back(cyc); n_rpt++; end
    endtask

    // Hold reset for n clocks with key level k; release away from the edge.
    task automatic do_reset(input int n, input bit k);
        kif.click_n = k;
        rst_n = 1'b0;
        #1;
        chk("rst_out", 32'({kif.short_p, kif.double_p, kif.long_p, kif.repeat_p}), 32'd0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("rst_out", 32'({kif.short_p, kif.double_p, kif.long_p, kif.repeat_p}), 32'd0);
        end
        chk("rst_state", 32'(dut.r_state), 32'd0);
        chk("rst_cnt", 32'(dut.r_cnt), 32'd0);
        rst_n = 1'b1;
        g_phase = 0;
    endtask

    function automatic int pick_press();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(1, 12));
            1:       return int'($urandom_range(98, 102));
            2:       return int'($urandom_range(103, 170));
            default: return int'($urandom_range(13, 60));
        endcase
    endfunction

    function automatic int pick_gap();
        case ($urandom_range(0, 2))
            0:       return int'($urandom_range(1, 8));
            1:       return int'($urandom_range(28, 32));
            default: return int'($urandom_range(33, 50));
        endcase
    endfunction

    // Directed scenarios followed by randomized gestures.
    initial begin
        int p;
        int rel;
        kif.click_n = 1'b1;
        clear_log();

        do_reset(3, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1);

        // Short click: short_p 31 cycles after release, nothing else.
        clear_log();
        for (int i = 0; i < 10; i++) step(1'b0);
        rel = cyc;
        for (int i = 0; i < 50; i++) step(1'b1);
        chk("short_lat", 32'(t_short - rel), 32'd31);
        chk("short_cnt", 32'(n_short), 32'd1);
        chk("short_other", 32'(n_double + n_long + n_rpt), 32'd0);

        // Double click: double_p 1 cycle after second release, no short.
        clear_log();
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 10; i++) step(1'b1);
        for (int i = 0; i < 10; i++) step(1'b0);
        rel = cyc;
        for (int i = 0; i < 40; i++) step(1'b1);
        chk("dbl_lat", 32'(t_double - rel), 32'd1);
        chk("dbl_cnt", 32'(n_double), 32'd1);
        chk("dbl_noshort", 32'(n_short), 32'd0);

        // Long hold with repeats, silent release.
        clear_log();
        p = cyc;
        for (int i = 0; i < 165; i++) step(1'b0);
        for (int i = 0; i < 40; i++) step(1'b1);
        chk("long_lat", 32'(t_long - p), 32'd101);
        chk("rpt_cnt", 32'(rpt_q.size()), 32'd3);
        if (rpt_q.size() == 3) begin
            chk("rpt0", 32'(rpt_q[0] - p), 32'd121);
            chk("rpt1", 32'(rpt_q[1] - p), 32'd141);
            chk("rpt2", 32'(rpt_q[2] - p), 32'd161);
        end
        chk("long_other", 32'(n_short + n_double), 32'd0);

        // Release on the last cycle before long: short, not long.
        clear_log();
        for (int i = 0; i < 100; i++) step(1'b0);
        rel = cyc;
        for (int i = 0; i < 40; i++) step(1'b1);
        chk("edge_nolong", 32'(n_long), 32'd0);
        chk("edge_short", 32'(t_short - rel), 32'd31);

        // Second press on the last cycle of the window: double, not short.
        clear_log();
        for (int i = 0; i < 10; i++) step(1'b0);
        for (int i = 0; i < 30; i++) step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        rel = cyc;
        for (int i = 0; i < 40; i++) step(1'b1);
        chk("edge_noshort", 32'(n_short), 32'd0);
        chk("edge_dbl", 32'(t_double - rel), 32'd1);

        // Reset during first press, then during hold: no pulses afterwards.
        for (int i = 0; i < 51; i++) step(1'b0);
        do_reset(3, 1'b1);
        clear_log();
        for (int i = 0; i < 150; i++) step(1'b1);
        chk("rst_p1_quiet", 32'(n_short + n_double + n_long + n_rpt), 32'd0);
        for (int i = 0; i < 130; i++) step(1'b0);
        do_reset(3, 1'b1);
        clear_log();
        for (int i = 0; i < 150; i++) step(1'b1);
        chk("rst_hold_quiet", 32'(n_short + n_double + n_long + n_rpt), 32'd0);

        // Key held low through reset release counts as a fresh press.
        do_reset(3, 1'b0);
        clear_log();
        p = cyc;
        for (int i = 0; i < 110; i++) step(1'b0);
        chk("rst_low_long", 32'(t_long - p), 32'd101);
        for (int i = 0; i < 10; i++) step(1'b1);

        // Randomized gestures around the timing thresholds.
        for (int g = 0; g < 60; g++) begin
            int len;
            int gap;
            if ($urandom_range(0, 9) == 0) do_reset(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            len = pick_press();
            for (int i = 0; i < len; i++) step(1'b0);
            gap = pick_gap();
            for (int i = 0; i < gap; i++) step(1'b1);
        end
        for (int i = 0; i < 40; i++) step(1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_key_event_decoder

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_TIME, default 50_000_000: hold cycles before a long press (1 s at 50 MHz).
REQ-002 Parameter DBL_TIME, default 15_000_000: release window for a second press (300 ms).
REQ-003 Parameter RPT_TIME, default 10_000_000: auto-repeat period while held after a long press (200 ms).
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 click_n  input  1  debounced key level, active-low, synchronous to clk.
REQ-007 short_p  output  1  one-cycle pulse: single short click.
REQ-008 double_p  output  1  one-cycle pulse: double click.
REQ-009 long_p  output  1  one-cycle pulse: hold reached LONG_TIME.
REQ-010 repeat_p  output  1  one-cycle pulse: auto-repeat tick during hold.

Function
REQ-011 The block SHALL be a 5-state FSM: IDLE, PRESS1, WAIT2, PRESS2, HOLD, with one shared cycle counter `cnt`.
REQ-012 The counter SHALL be 26 bits wide, SHALL clear on every state change, and SHALL never wrap (every state exits or clears `cnt` at its terminal count).
REQ-013 IDLE: click_n==0 -> PRESS1; otherwise stay in IDLE.
REQ-014 PRESS1: click_n==1 -> WAIT2; else if cnt==LONG_TIME-1 -> HOLD with long_p=1 for one cycle; else cnt++.
REQ-015 WAIT2: click_n==0 -> PRESS2; else if cnt==DBL_TIME-1 -> IDLE with short_p=1 for one cycle; else cnt++.
REQ-016 PRESS2: click_n==1 -> IDLE with double_p=1 for one cycle; no long detection occurs in PRESS2, regardless of hold duration.
REQ-017 HOLD: click_n==1 -> IDLE, no pulse; else if cnt==RPT_TIME-1 -> repeat_p=1 for one cycle and cnt=0; else cnt++.
REQ-018 Simultaneous events: the key level SHALL take priority over the terminal count in every state. Release on the LONG_TIME-1 cycle yields WAIT2, not long_p. A press on the DBL_TIME-1 cycle yields PRESS2, not short_p.
REQ-019 All pulse outputs SHALL be registered and mutually exclusive. Each pulse SHALL be high for exactly one clk cycle, in the cycle after the deciding input sample.
REQ-020 Per gesture, latency SHALL be:
- short click: DBL_TIME+1 cycles after release
- double click: 1 cycle after second release
- long press: LONG_TIME+1 cycles after press
REQ-021 A key low at reset release SHALL be treated as a new press (IDLE -> PRESS1 on the first clock).

Reset
REQ-022 While rst_n==0, the block SHALL hold state=IDLE, cnt=0, and short_p=double_p=long_p=repeat_p=0.
REQ-023 Reset asserted mid-gesture SHALL discard the gesture without emitting any pulse.

Structure
REQ-024 The state encodings and default timing constants SHALL reside in a shared include file, alongside the debounce MASK_TIME constant, for reuse by the player control logic.
REQ-025 The block SHALL be a single module with no sub-modules; the counter and FSM SHALL share one clocked process, with pulse outputs registered.
REQ-026 The block SHALL consume the debounced key directly, SHALL NOT add a synchronizer or debounce stage, and SHALL use one instance per key.

Verification (sim parameters LONG_TIME=100, DBL_TIME=30, RPT_TIME=20)
REQ-027 Press 10 cycles, release, idle 50 -> one short_p exactly 31 cycles after release; no other pulses.
REQ-028 Press 10, release 10, press 10, release -> one double_p 1 cycle after second release; no short_p.
REQ-029 Hold 165 cycles, release -> long_p at cycle 101, then repeat_p at cycles 121, 141, 161; nothing on release.
REQ-030 Release exactly on cycle 99 of first press -> no long_p; short_p 31 cycles later. Second press on WAIT2 cycle 29 -> double_p, no short_p.
REQ-031 Assert rst_n=0 for 3 cycles during PRESS1 (cnt=50) and during HOLD -> all outputs 0, state IDLE, no pulse afterwards with key high.
REQ-032 Key held low through reset release -> long_p 101 cycles after the first clock with rst_n=1.
